// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings
// and requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection between the core and debug ports.
// Default build: round-robin, the port that did not win last takes a conflict.
// With MEM_ARB_FIXED_PRIO_EN defined the core port always wins a conflict
// and rr_last is ignored.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 rr_last_i,
    output logic                 gnt_vld_o,
    output logic                 gnt_idx_o
);

    // Pick the winning port index; a lone requester always wins
    always_comb begin
        gnt_vld_o = |req_i;
        gnt_idx_o = PORT_CORE;
        if (req_i[PORT_CORE] && req_i[PORT_DBG]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt_idx_o = PORT_CORE;
`else
            gnt_idx_o = ~rr_last_i;
`endif
        end else if (req_i[PORT_DBG]) begin
            gnt_idx_o = PORT_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between the core (port 0) and
// the debug/program loader (port 1). Request is latched at grant, memory is
// driven for WAIT_CYCLES cycles, then a one-cycle done pulse is issued.
// Optional: MEM_ARB_FIXED_PRIO_EN makes port 0 win every conflict.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    wdata0,
    input  logic [DATA_W-1:0]    wdata1,
    output logic [1:0]           done,
    output logic [DATA_W-1:0]    rdata0,
    output logic [DATA_W-1:0]    rdata1,
    output logic                 busy,
    output logic                 owner,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    // Counter preload: cnt runs WAIT_CYCLES-1 down to 0 inside ACCESS
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e                      state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            owner_q, owner_d;
    logic                            rr_last_q, rr_last_d;
    logic                            we_q, we_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [DATA_W-1:0]               wdata_q, wdata_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_in;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_in;
    logic                            gnt_vld, gnt_idx;
    logic                            in_access;

    assign addr_in  = {addr1, addr0};
    assign wdata_in = {wdata1, wdata0};

    arb_rr_pick u_pick (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // State, counter, latched request and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= PORT_CORE;
            rr_last_q <= PORT_DBG;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state: grant in IDLE, count wait states in ACCESS, pulse in DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    we_d    = we[gnt_idx];
                    addr_d  = addr_in[gnt_idx];
                    wdata_d = wdata_in[gnt_idx];
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Writes leave the owner's read data untouched
                    if (!we_q)
                        rdata_d[owner_q] = mem_rdata;
                    rr_last_d = owner_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side is quiet outside ACCESS; done is decoded from the DONE state
    always_comb begin
        in_access = (state_q == ACCESS);
        mem_en    = in_access;
        mem_we    = in_access & we_q;
        mem_addr  = in_access ? addr_q  : '0;
        mem_wdata = in_access ? wdata_q : '0;
        done      = '0;
        if (state_q == DONE)
            done[owner_q] = 1'b1;
    end

    assign busy   = (state_q != IDLE);
    assign owner  = owner_q;
    assign rdata0 = rdata_q[PORT_CORE];
    assign rdata1 = rdata_q[PORT_DBG];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=2 and a
// second with WAIT_CYCLES=1. Inputs driven and outputs sampled on negedge.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WAIT_CYCLES=2 instance
    logic [1:0]  req, we, done;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
    logic        busy, owner, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // WAIT_CYCLES=1 instance
    logic [1:0]  b_req, b_we, b_done;
    logic [31:0] b_addr0, b_addr1, b_wdata0, b_wdata1, b_rdata0, b_rdata1;
    logic        b_busy, b_owner, b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done(done), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .owner(owner), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .done(b_done), .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
        .owner(b_owner), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int exp_own;
        logic [31:0] exp_rd;

        rst = 1'b1;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0;
        b_req = '0; b_we = '0; b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        b_mem_rdata = '0;
        @(negedge clk);
        step();

        // Reset state
        chk("rst_done",   32'(done),      32'h0);
        chk("rst_rdata0", rdata0,         32'h0);
        chk("rst_rdata1", rdata1,         32'h0);
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_owner",  32'(owner),     32'h0);
        chk("rst_mem_en", 32'(mem_en),    32'h0);
        chk("rst_mem_we", 32'(mem_we),    32'h0);
        chk("rst_maddr",  mem_addr,       32'h0);
        chk("rst_mwdata", mem_wdata,      32'h0);
        chk("rst_b_busy", 32'(b_busy),    32'h0);
        rst = 1'b0;

        // Port 0 read of 0x10
        req = 2'b01; we = 2'b00; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
        step();
        chk("rd0_en1",    32'(mem_en),  32'h1);
        chk("rd0_we1",    32'(mem_we),  32'h0);
        chk("rd0_addr1",  mem_addr,     32'h10);
        chk("rd0_busy",   32'(busy),    32'h1);
        chk("rd0_done1",  32'(done),    32'h0);
        step();
        chk("rd0_en2",    32'(mem_en),  32'h1);
        chk("rd0_addr2",  mem_addr,     32'h10);
        step();
        chk("rd0_done",   32'(done),    32'h1);
        chk("rd0_en_off", 32'(mem_en),  32'h0);
        chk("rd0_rdata",  rdata0,       32'hDEADBEEF);
        req = 2'b00;
        step();
        chk("rd0_idle",   32'(busy),    32'h0);
        chk("rd0_dn_off", 32'(done),    32'h0);

        // Port 1 write of 0x12345678 to 0x20
        req = 2'b10; we = 2'b10; addr1 = 32'h20; wdata1 = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wr1_en",    32'(mem_en), 32'h1);
            chk("wr1_we",    32'(mem_we), 32'h1);
            chk("wr1_addr",  mem_addr,    32'h20);
            chk("wr1_wdata", mem_wdata,   32'h12345678);
            chk("wr1_owner", 32'(owner),  32'h1);
        end
        step();
        chk("wr1_done",   32'(done),    32'h2);
        chk("wr1_rdata1", rdata1,       32'h0);
        chk("wr1_we_off", 32'(mem_we),  32'h0);
        req = 2'b00; we = 2'b00;
        step();

        // Continuous conflict: four accesses
        req = 2'b11; we = 2'b00; addr0 = 32'h30; addr1 = 32'h40;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_own = 0;
`else
            exp_own = k % 2;
`endif
            exp_rd = 32'hC0DE0000 + 32'(k);
            mem_rdata = exp_rd;
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (done == 2'b00 && cyc < 20);
            chk("rr_spacing", 32'(cyc), (k == 0) ? 32'd3 : 32'd4);
            chk("rr_owner",   32'(owner), 32'(exp_own));
            chk("rr_done",    32'(done),  (exp_own == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata",   (exp_own == 0) ? rdata0 : rdata1, exp_rd);
        end
        req = 2'b00;
        step();

        // Reset in the second ACCESS cycle
        req = 2'b01; we = 2'b00; addr0 = 32'h50;
        step();
        step();
        chk("mid_en",     32'(mem_en), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_busy",   32'(busy),   32'h0);
        chk("mid_en_off", 32'(mem_en), 32'h0);
        chk("mid_done",   32'(done),   32'h0);
        chk("mid_rdata0", rdata0,      32'h0);
        chk("mid_rdata1", rdata1,      32'h0);
        rst = 1'b0; req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_nodone", 32'(done), 32'h0);
        end

        // Inputs latched at grant: addr change after grant is ignored
        req = 2'b01; we = 2'b00; addr0 = 32'h10; mem_rdata = 32'h0BADF00D;
        step();
        addr0 = 32'h99;
        chk("lat_addr1",  mem_addr, 32'h10);
        step();
        chk("lat_addr2",  mem_addr, 32'h10);
        step();
        chk("lat_done",   32'(done), 32'h1);
        chk("lat_rdata",  rdata0,    32'h0BADF00D);
        req = 2'b00;
        step();

        // WAIT_CYCLES=1 instance: single read
        b_req = 2'b01; b_we = 2'b00; b_addr0 = 32'h44; b_mem_rdata = 32'h5A5A5A5A;
        step();
        chk("w1_en",      32'(b_mem_en), 32'h1);
        chk("w1_addr",    b_mem_addr,    32'h44);
        chk("w1_done0",   32'(b_done),   32'h0);
        step();
        chk("w1_done",    32'(b_done),   32'h1);
        chk("w1_en_off",  32'(b_mem_en), 32'h0);
        chk("w1_rdata",   b_rdata0,      32'h5A5A5A5A);
        b_req = 2'b00;
        step();
        chk("w1_idle",    32'(b_busy),   32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two requesters: port 0 is the multicycle core's memory interface (fetch and load/store); port 1 is the debug/program loader.
- Sits between the core controller/datapath and the memory model.
- Round-robin arbitration, req/done handshake, programmable wait states.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, cycles mem_en is held per access; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- req  in  2  per-port request; bit i = port i
- we  in  2  per-port write enable
- addr0, addr1  in  ADDR_W  per-port address
- wdata0, wdata1  in  DATA_W  per-port write data
- done  out  2  per-port one-cycle completion pulse
- rdata0, rdata1  out  DATA_W  per-port read data, registered
- busy  out  1  access in progress (state != IDLE)
- owner  out  1  index of the current or last granted port
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset is synchronous, active-high, on clk. Applied values:
  - state=IDLE
  - done=0, rdata0=rdata1=0, owner=0, busy=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - rr_last=1, so port 0 wins the first conflict.
- States:
  - IDLE: if any req bit is set, latch winner → owner, and latch the winner's we, addr, wdata. Set cnt=WAIT_CYCLES-1 and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_en=1; mem_we, mem_addr, mem_wdata driven from the latched copies for every ACCESS cycle.
    - If cnt==0: capture mem_rdata into the owner's rdata (reads only; writes leave rdata unchanged), set rr_last=owner, go to DONE.
    - Else decrement cnt.
  - DONE: done[owner]=1 for exactly this cycle; mem_en=0; next state is IDLE.
- Memory-side outputs are 0 whenever state != ACCESS.
- Arbitration: if only one req bit is set, that port wins. If both are set, the winner is the port != rr_last.
- Latency: req sampled in IDLE at cycle t; mem_en high for cycles t+1..t+WAIT_CYCLES; done high in cycle t+WAIT_CYCLES+1.
- Next possible grant: IDLE at t+WAIT_CYCLES+2.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it sees done.
  - Requester drops req on the clock edge that ends the done cycle; a req still high in IDLE starts a new access.
  - Inputs are latched at grant, so changes made after grant do not corrupt the access.
- rdata_i holds its value until port i's next read completes.
- The losing requester waits, with no timeout and no starvation. Back-to-back conflicting requests alternate 0,1,0,1.
- Repeated identical write cycles while mem_we is held are acceptable; the memory commits the write idempotently.
- Reset mid-ACCESS or mid-DONE: the access is abandoned, no done is issued, and the reset values apply the next cycle.
- cnt is 4 bits wide. WAIT_CYCLES=1 means a single ACCESS cycle with cnt=0 at entry.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins conflicts; rr_last is ignored (it may be omitted). This lets the core starve the loader.
- Undefined: round-robin arbitration as specified above.

Decomposition:
- Package mem_arb_pkg holds:
  - state encodings: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10
  - port index constants: PORT_CORE=0, PORT_DBG=1
- Sub-module arb_rr_pick: combinational winner selection from req and rr_last, with the MEM_ARB_FIXED_PRIO_EN variant inside it.
- The FSM, counter and latches stay in mem_port_arbiter.

Test Plan:
- Reset, then port 0 read of addr 0x10 with mem_rdata=0xDEADBEEF, WAIT_CYCLES=2 → mem_en high exactly 2 cycles with mem_addr=0x10; done=2'b01 at cycle t+3; rdata0=0xDEADBEEF.
- Port 1 write of addr 0x20, wdata 0x12345678 → mem_we=mem_en=1 for 2 cycles with the correct addr/data; done=2'b10; rdata1 unchanged at 0.
- Both ports request continuously for 4 accesses → grant order 0,1,0,1, with done pulses spaced WAIT_CYCLES+2 apart. With MEM_ARB_FIXED_PRIO_EN defined the order is 0,0,0,0.
- Assert rst during the second ACCESS cycle → next cycle busy=0, mem_en=0, done never pulses, rdata0=rdata1=0.
- Port 0 changes addr from 0x10 to 0x99 in the cycle after grant → mem_addr stays 0x10 for the whole access.
- WAIT_CYCLES=1 single read → mem_en high for 1 cycle; done at t+2.
